// File: rtl/countdown_sequencer.sv
// Countdown sequencer driving the seconds-tick divider: load/run/pause/cancel
// with an expiry pulse and a tick-counted alarm window.
module countdown_sequencer #(
   parameter int WIDTH       = 8,
   parameter int ALARM_TICKS = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             tick,
   input  logic             start,
   input  logic             pause,
   input  logic             cancel,
   input  logic [WIDTH-1:0] load_value,
   output logic             divider_reset,
   output logic [WIDTH-1:0] remaining,
   output logic             busy,
   output logic             expired,
   output logic             alarm,
   output logic [1:0]       state
);

   localparam int AW = (ALARM_TICKS < 1) ? 1 : $clog2(ALARM_TICKS + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      ALARM  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] remaining_q, remaining_d;
   logic [AW-1:0]    acnt_q, acnt_d;
   logic             divrst_q, divrst_d;
   logic             expired_q, expired_d;
   logic             busy_q, alarm_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         acnt_q      <= '0;
         divrst_q    <= 1'b0;
         expired_q   <= 1'b0;
         busy_q      <= 1'b0;
         alarm_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         acnt_q      <= acnt_d;
         divrst_q    <= divrst_d;
         expired_q   <= expired_d;
         busy_q      <= (state_d == RUN) || (state_d == PAUSED);
         alarm_q     <= (state_d == ALARM);
      end
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      acnt_d      = acnt_q;
      divrst_d    = 1'b0;
      expired_d   = 1'b0;

      if (cancel) begin
         state_d     = IDLE;
         remaining_d = '0;
         acnt_d      = '0;
      end else if (start) begin
         if (load_value != '0) begin
            state_d     = RUN;
            remaining_d = load_value;
            divrst_d    = 1'b1;
         end else begin
            state_d     = ALARM;
            remaining_d = '0;
            expired_d   = 1'b1;
            acnt_d      = AW'(ALARM_TICKS);
         end
      end else begin
         unique case (state_q)
            IDLE: ;
            RUN: begin
               if (pause) begin
                  state_d = PAUSED;
               end else if (tick) begin
                  if (remaining_q > WIDTH'(1)) begin
                     remaining_d = remaining_q - WIDTH'(1);
                  end else if (remaining_q == WIDTH'(1)) begin
                     remaining_d = '0;
                     expired_d   = 1'b1;
                     state_d     = ALARM;
                     acnt_d      = AW'(ALARM_TICKS);
                  end
               end
            end
            // Resuming restarts the divider so the next tick is a full period away
            PAUSED: begin
               if (!pause) begin
                  state_d  = RUN;
                  divrst_d = 1'b1;
               end
            end
            ALARM: begin
               if (ALARM_TICKS == 0) begin
                  state_d = IDLE;
               end else if (tick) begin
                  if (acnt_q <= AW'(1)) begin
                     acnt_d  = '0;
                     state_d = IDLE;
                  end else begin
                     acnt_d = acnt_q - AW'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign divider_reset = divrst_q;
   assign remaining     = remaining_q;
   assign busy          = busy_q;
   assign expired       = expired_q;
   assign alarm         = alarm_q;
   assign state         = state_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer: directed vector table, hand sequences for
// async reset and full-range countdown, then random traffic against a model.
module tb_countdown_sequencer;

   localparam int WIDTH = 8;
   localparam int ATK   = 4;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             tick = 1'b0, start = 1'b0, pause = 1'b0, cancel = 1'b0;
   logic [WIDTH-1:0] load_value = '0;
   logic             divider_reset, busy, expired, alarm;
   logic [WIDTH-1:0] remaining;
   logic [1:0]       state;

   int passed = 0;
   int total  = 0;

   countdown_sequencer #(.WIDTH(WIDTH), .ALARM_TICKS(ATK)) dut (
      .clock(clock), .reset(reset), .tick(tick), .start(start),
      .pause(pause), .cancel(cancel), .load_value(load_value),
      .divider_reset(divider_reset), .remaining(remaining), .busy(busy),
      .expired(expired), .alarm(alarm), .state(state)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit        s, t, p, c;
      int        ld;
      bit [13:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic bit [13:0] pk(input bit dr, input int rem, input bit bz,
                                    input bit ex, input bit al, input int st);
      bit [7:0] r;
      bit [1:0] s2;
      r  = rem[7:0];
      s2 = st[1:0];
      return {dr, r, bz, ex, al, s2};
   endfunction

   function automatic vec_t v(input bit s, t, p, c, input int ld, input bit [13:0] e);
      vec_t x;
      x.s = s; x.t = t; x.p = p; x.c = c; x.ld = ld; x.exp = e;
      return x;
   endfunction

   function automatic bit [13:0] dut_out();
      return {divider_reset, remaining, busy, expired, alarm, state};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
   endtask

   task automatic step(input bit s, t, p, c, input int ld);
      start = s; tick = t; pause = p; cancel = c; load_value = ld[WIDTH-1:0];
      @(posedge clock);
      #1;
   endtask

   // Reference model: counting/paused/alarming flags plus tick counts
   bit m_active, m_paused, m_alarming, m_dr, m_exp;
   int m_rem, m_left;

   task automatic model_reset();
      m_active = 0; m_paused = 0; m_alarming = 0; m_dr = 0; m_exp = 0;
      m_rem = 0; m_left = 0;
   endtask

   task automatic model_step(input bit s, t, p, c, input int ld);
      m_dr = 0; m_exp = 0;
      if (c) begin
         m_active = 0; m_paused = 0; m_alarming = 0; m_rem = 0; m_left = 0;
      end else if (s) begin
         m_paused = 0;
         if (ld != 0) begin
            m_rem = ld; m_active = 1; m_alarming = 0; m_dr = 1;
         end else begin
            m_rem = 0; m_active = 0; m_alarming = 1; m_left = ATK; m_exp = 1;
         end
      end else if (m_alarming) begin
         if (ATK == 0) m_alarming = 0;
         else if (t) begin
            m_left = m_left - 1;
            if (m_left == 0) m_alarming = 0;
         end
      end else if (m_active && m_paused) begin
         if (!p) begin m_paused = 0; m_dr = 1; end
      end else if (m_active) begin
         if (p) m_paused = 1;
         else if (t) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
               m_active = 0; m_alarming = 1; m_left = ATK; m_exp = 1;
            end
         end
      end
   endtask

   function automatic bit [13:0] model_out();
      int st;
      st = m_alarming ? 3 : (m_active ? (m_paused ? 2 : 1) : 0);
      return pk(m_dr, m_rem, m_active, m_exp, m_alarming, st);
   endfunction

   initial begin
      bit pz;
      // load 3, count to expiry, alarm window of 4 ticks
      tbl.push_back(v(1,0,0,0, 3, pk(1,3,1,0,0,1)));
      tbl.push_back(v(0,1,0,0, 0, pk(0,2,1,0,0,1)));
      tbl.push_back(v(0,0,0,0, 0, pk(0,2,1,0,0,1)));
      tbl.push_back(v(0,1,0,0, 0, pk(0,1,1,0,0,1)));
      tbl.push_back(v(0,1,0,0, 0, pk(0,0,0,1,1,3)));
      tbl.push_back(v(0,0,0,0, 0, pk(0,0,0,0,1,3)));
      tbl.push_back(v(0,1,0,0, 0, pk(0,0,0,0,1,3)));
      tbl.push_back(v(0,1,0,0, 0, pk(0,0,0,0,1,3)));
      tbl.push_back(v(0,1,1,0, 0, pk(0,0,0,0,1,3)));
      tbl.push_back(v(0,1,0,0, 0, pk(0,0,0,0,0,0)));
      tbl.push_back(v(0,1,0,0, 0, pk(0,0,0,0,0,0)));
      tbl.push_back(v(0,1,0,0, 0, pk(0,0,0,0,0,0)));
      // load 5, pause with coincident tick, hold, resume
      tbl.push_back(v(1,0,0,0, 5, pk(1,5,1,0,0,1)));
      tbl.push_back(v(0,1,0,0, 0, pk(0,4,1,0,0,1)));
      tbl.push_back(v(0,1,0,0, 0, pk(0,3,1,0,0,1)));
      tbl.push_back(v(0,1,1,0, 0, pk(0,3,1,0,0,2)));
      for (int i = 0; i < 10; i++) tbl.push_back(v(0,1,1,0, 0, pk(0,3,1,0,0,2)));
      tbl.push_back(v(0,0,0,0, 0, pk(1,3,1,0,0,1)));
      tbl.push_back(v(0,1,0,0, 0, pk(0,2,1,0,0,1)));
      // start beats tick; cancel beats start
      tbl.push_back(v(1,1,0,0, 9, pk(1,9,1,0,0,1)));
      tbl.push_back(v(1,0,0,1, 4, pk(0,0,0,0,0,0)));
      // zero load goes straight to alarm; cancel during alarm
      tbl.push_back(v(1,0,0,0, 0, pk(0,0,0,1,1,3)));
      tbl.push_back(v(0,0,1,0, 0, pk(0,0,0,0,1,3)));
      tbl.push_back(v(0,0,0,1, 0, pk(0,0,0,0,0,0)));
      // start while paused, then cancel while running
      tbl.push_back(v(1,0,0,0, 2, pk(1,2,1,0,0,1)));
      tbl.push_back(v(0,0,1,0, 0, pk(0,2,1,0,0,2)));
      tbl.push_back(v(1,1,1,0, 6, pk(1,6,1,0,0,1)));
      tbl.push_back(v(0,0,0,0, 0, pk(0,6,1,0,0,1)));
      tbl.push_back(v(0,1,0,1, 0, pk(0,0,0,0,0,0)));

      repeat (2) @(posedge clock);
      #1;
      chk("reset_state", dut_out(), pk(0,0,0,0,0,0));
      reset = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].s, tbl[i].t, tbl[i].p, tbl[i].c, tbl[i].ld);
         chk($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
      end

      // full-range countdown with no wrap
      step(1,0,0,0, 255);
      chk("ld255", dut_out(), pk(1,255,1,0,0,1));
      for (int i = 254; i >= 1; i--) begin
         step(0,1,0,0, 0);
         chk($sformatf("cnt255_%0d", i), remaining, i);
      end
      step(0,1,0,0, 0);
      chk("cnt255_zero", dut_out(), pk(0,0,0,1,1,3));
      for (int i = 0; i < 6; i++) begin
         step(0,1,0,0, 0);
         chk($sformatf("nowrap%0d", i), remaining, 0);
      end
      step(0,0,0,0, 0);
      chk("after255_idle", dut_out(), pk(0,0,0,0,0,0));

      // asynchronous reset between edges while running at 7
      step(1,0,0,0, 7);
      chk("ld7", dut_out(), pk(1,7,1,0,0,1));
      step(0,0,0,0, 0);
      #2 reset = 1'b0;
      #1 chk("async_clear", dut_out(), pk(0,0,0,0,0,0));
      step(0,1,0,0, 0);
      chk("held_in_reset", dut_out(), pk(0,0,0,0,0,0));
      reset = 1'b1;
      step(0,1,0,0, 0);
      chk("no_expiry_after_reset", dut_out(), pk(0,0,0,0,0,0));

      // randomized traffic against the model
      model_reset();
      pz = 0;
      for (int n = 0; n < 1500; n++) begin
         bit s, t, c;
         int ld;
         s  = ($urandom_range(0, 15) == 0);
         c  = ($urandom_range(0, 39) == 0);
         t  = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 9) == 0) pz = ~pz;
         ld = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
         model_step(s, t, pz, c, ld);
         step(s, t, pz, c, ld);
         chk($sformatf("rand%0d", n), dut_out(), model_out());
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
